// File: rtl/cfg_chain_pkg.sv
// Shared types and default sizing for the configuration chain loader.
// Chain lengths, clock divider and FSM state encoding live here.
package cfg_chain_pkg;

    localparam int DEF_SIZESRSTAT = 88;
    localparam int DEF_SIZESRDYN  = 16;
    localparam int DEF_HALF       = 4;
    localparam int DEF_N          = DEF_SIZESRSTAT + DEF_SIZESRDYN;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        FINISH
    } state_t;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_sclk_gen.sv
// Chain shift-clock generator: SCLK low for HALF cycles, then high for HALF.
// Strobes mark the last cycle of the low half and of the high half.
module cfg_sclk_gen
    import cfg_chain_pkg::*;
#(
    parameter int HALF = DEF_HALF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_quiet,
    output logic o_sclk,
    output logic o_pre_rise,
    output logic o_phase_end
);

    localparam int             HW   = cnt_width(HALF);
    localparam logic [HW-1:0]  LAST = HW'(HALF - 1);

    logic [HW-1:0] r_cnt;
    logic          r_phase;
    logic          r_sclk;
    logic          w_wrap;

    assign w_wrap      = i_en && (r_cnt == LAST);
    assign o_pre_rise  = w_wrap && !r_phase;
    assign o_phase_end = w_wrap && r_phase;
    assign o_sclk      = r_sclk;

    // The phase keeps running while quiet so the latch window has the
    // same length as a bit period, but the pin itself stays low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= !r_phase;
            r_sclk  <= !r_phase && !i_quiet;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serial loader for the static+dynamic configuration chain with an optional
// second pass that checks the chain's SDO stream against the written frame.
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int SIZESRSTAT = DEF_SIZESRSTAT,
    parameter int SIZESRDYN  = DEF_SIZESRDYN,
    parameter int HALF       = DEF_HALF
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic                            VERIFY,
    input  logic [SIZESRSTAT-1:0]           STATDATA,
    input  logic [SIZESRDYN-1:0]            DYNDATA,
    input  logic                            SDO,
    output logic                            SCLK,
    output logic                            SEL,
    output logic                            SDI,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            ERR,
    output logic [SIZESRSTAT+SIZESRDYN-1:0] RDBK
);

    localparam int            N        = SIZESRSTAT + SIZESRDYN;
    localparam int            BW       = cnt_width(N);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    state_t        r_state;
    logic [N-1:0]  r_frame;
    logic [N-1:0]  r_rdbk;
    logic [BW-1:0] r_bit;
    logic          r_pass;
    logic          r_verify;
    logic          r_sel;
    logic          r_sdi;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_en;
    logic          w_quiet;
    logic          w_sclk;
    logic          w_pre_rise;
    logic          w_phase_end;

    assign w_en    = (r_state == SHIFT) || (r_state == LATCH);
    assign w_quiet = (r_state == LATCH);

    cfg_sclk_gen #(
        .HALF(HALF)
    ) u_sclk_gen (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_en       (w_en),
        .i_quiet    (w_quiet),
        .o_sclk     (w_sclk),
        .o_pre_rise (w_pre_rise),
        .o_phase_end(w_phase_end)
    );

    assign SCLK = w_sclk;
    assign SEL  = r_sel;
    assign SDI  = r_sdi;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign ERR  = r_err;
    assign RDBK = r_rdbk;

    // The frame rotates rather than shifts out, so after N bits it is back
    // in its original form and the verify pass can reuse it untouched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_frame  <= '0;
            r_rdbk   <= '0;
            r_bit    <= '0;
            r_pass   <= 1'b0;
            r_verify <= 1'b0;
            r_sel    <= 1'b0;
            r_sdi    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_state  <= SHIFT;
                        r_frame  <= {STATDATA, DYNDATA};
                        r_verify <= VERIFY;
                        r_pass   <= 1'b0;
                        r_bit    <= '0;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_sel    <= 1'b1;
                        r_sdi    <= STATDATA[SIZESRSTAT-1];
                    end
                end

                SHIFT: begin
                    if (w_pre_rise) begin
                        r_rdbk <= {r_rdbk[N-2:0], SDO};
                        if (r_pass && (SDO != r_frame[N-1])) begin
                            r_err <= 1'b1;
                        end
                    end
                    if (w_phase_end) begin
                        r_frame <= {r_frame[N-2:0], r_frame[N-1]};
                        if (r_bit == LAST_BIT) begin
                            r_state <= LATCH;
                            r_sdi   <= 1'b0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_sdi <= r_frame[N-2];
                        end
                    end
                end

                LATCH: begin
                    if (w_pre_rise) begin
                        r_sel <= 1'b0;
                    end
                    if (w_phase_end) begin
                        if (!r_pass && r_verify) begin
                            r_state <= SHIFT;
                            r_pass  <= 1'b1;
                            r_bit   <= '0;
                            r_sel   <= 1'b1;
                            r_sdi   <= r_frame[N-1];
                        end else begin
                            r_state <= FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                FINISH: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader with a behavioural shift-register chain
// that shifts SDI in on SCLK rises while SEL is high and drives its MSB on SDO.
module tb_cfg_chain_loader;

    localparam int N = 104;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          VERIFY = 1'b0;
    logic [87:0]   STATDATA = '0;
    logic [15:0]   DYNDATA = '0;
    logic          SDO;
    logic          SCLK, SEL, SDI, BUSY, DONE, ERR;
    logic [N-1:0]  RDBK;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0] chain;
    logic [N-1:0] nxt_c;
    logic [N-1:0] ld_val = '0;
    logic         ld = 1'b0;
    logic         stuck40 = 1'b0;
    int           rises;
    int           ones;

    int           done_at, sel_fall_at, rise_at;
    logic         err_at_done;

    always #5 CLK = ~CLK;

    cfg_chain_loader #(
        .SIZESRSTAT(88),
        .SIZESRDYN (16),
        .HALF      (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .VERIFY  (VERIFY),
        .STATDATA(STATDATA),
        .DYNDATA (DYNDATA),
        .SDO     (SDO),
        .SCLK    (SCLK),
        .SEL     (SEL),
        .SDI     (SDI),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR),
        .RDBK    (RDBK)
    );

    assign SDO = chain[N-1];

    always @(posedge SCLK or posedge ld) begin
        if (ld) begin
            chain <= ld_val;
            rises <= 0;
            ones  <= 0;
        end else if (SEL) begin
            nxt_c = {chain[N-2:0], SDI};
            if (stuck40) nxt_c[40] = 1'b0;
            chain <= nxt_c;
            rises <= rises + 1;
            ones  <= ones + int'(SDI);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [N-1:0] v);
        ld_val = v;
        ld = 1'b1;
        #1;
        ld = 1'b0;
    endtask

    // Launch one transfer and watch it; times are in cycles after the START edge.
    task automatic run_xfer(input logic [87:0] st, input logic [15:0] dy, input logic ver,
                            input int pulse_at, input int rst_at, input int max_cyc);
        done_at = -1; sel_fall_at = -1; rise_at = -1; err_at_done = 1'b0;
        @(negedge CLK);
        STATDATA = st; DYNDATA = dy; VERIFY = ver; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0; STATDATA = ~st; DYNDATA = ~dy; VERIFY = ~ver;
        for (int j = 1; j <= max_cyc && done_at < 0; j++) begin
            @(negedge CLK);
            if (j == 1) begin
                chk("busy_t1", BUSY, 1);
                chk("sel_t1", SEL, 1);
                chk("sclk_t1", SCLK, 0);
                chk("sdi_t1", SDI, st[87]);
                chk("err_clr", ERR, 0);
            end
            if (rise_at < 0 && SCLK) rise_at = j;
            if (sel_fall_at < 0 && !SEL) sel_fall_at = j;
            if (DONE) begin
                done_at = j;
                err_at_done = ERR;
                chk("busy_at_done", BUSY, 0);
            end
            if (j == pulse_at) begin
                START = 1'b1; STATDATA = ~st; DYNDATA = ~dy; VERIFY = 1'b1;
            end else begin
                START = 1'b0;
            end
            if (j == rst_at) begin
                RST = 1'b1;
                #1;
                chk("rst_sel", SEL, 0);
                chk("rst_sclk", SCLK, 0);
                chk("rst_sdi", SDI, 0);
                chk("rst_busy", BUSY, 0);
                chk("rst_rdbk", RDBK, 0);
                @(negedge CLK);
                RST = 1'b0;
            end
        end
        if (done_at >= 0) begin
            @(negedge CLK);
            chk("done_one_cycle", DONE, 0);
        end
    endtask

    initial begin
        logic [N-1:0] pat;
        logic [87:0]  st3;
        logic [15:0]  dy3;

        st3 = 88'h01_2345_6789_ABCD_EFFE_DCBA;
        dy3 = 16'h5A3C;
        pat = {13{8'hA5}};

        preload('0);
        repeat (3) @(negedge CLK);
        chk("reset_sel", SEL, 0);
        chk("reset_sclk", SCLK, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_done", DONE, 0);
        chk("reset_err", ERR, 0);
        chk("reset_rdbk", RDBK, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // All-ones frame, single pass
        run_xfer('1, '1, 1'b0, -1, -1, 2000);
        chk("t1_first_rise", rise_at, 5);
        chk("t1_sel_fall", sel_fall_at, 837);
        chk("t1_done", done_at, 841);
        chk("t1_err", err_at_done, 0);
        chk("t1_rises", rises, 104);
        chk("t1_sdi_ones", ones, 104);
        chk("t1_chain", chain, {N{1'b1}});

        // Readback of a preloaded chain
        preload(pat);
        run_xfer('0, '0, 1'b0, -1, -1, 2000);
        chk("t2_done", done_at, 841);
        chk("t2_rdbk", RDBK, pat);
        chk("t2_chain", chain, 0);

        // Verify pass with a healthy chain
        preload(pat);
        run_xfer(st3, dy3, 1'b1, -1, -1, 4000);
        chk("t3_done", done_at, 1681);
        chk("t3_err", err_at_done, 0);
        chk("t3_rdbk", RDBK, {st3, dy3});
        chk("t3_chain", chain, {st3, dy3});

        // Verify pass with chain bit 40 stuck low
        stuck40 = 1'b1;
        preload('0);
        run_xfer('1, '1, 1'b1, -1, -1, 4000);
        chk("t4_done", done_at, 1681);
        chk("t4_err", err_at_done, 1);
        repeat (5) @(negedge CLK);
        chk("t4_err_sticky", ERR, 1);
        stuck40 = 1'b0;

        // START during a transfer is ignored
        preload('0);
        run_xfer(st3, dy3, 1'b0, 100, -1, 4000);
        chk("t5_done", done_at, 841);
        chk("t5_chain", chain, {st3, dy3});
        chk("t5_rdbk", RDBK, 0);

        // Reset mid-transfer, then a clean restart
        preload('0);
        run_xfer('1, '1, 1'b0, -1, 300, 2000);
        chk("t6_no_done", done_at, -1);
        preload(pat);
        run_xfer(st3, dy3, 1'b0, -1, -1, 2000);
        chk("t6_done", done_at, 841);
        chk("t6_rdbk", RDBK, pat);
        chk("t6_chain", chain, {st3, dy3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Sequencer that writes the static (88-bit) and dynamic (16-bit) configuration chain through its serial port (SEL/SDI/clock) and collects what the chain shifts out on SDO. It sits between the control logic, which supplies parallel configuration words, and `config_register_latched_dec`. It generates the chain's shift clock from CLK, latches the new configuration by dropping SEL, and can run a second verify pass that compares the SDO stream bit by bit.

## Interface
- SIZESRSTAT, 88, static chain length
- SIZESRDYN, 16, dynamic chain length
- HALF, 4, CLK cycles per SCLK half-period (≥1)
---
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  load request; sampled only in IDLE
- VERIFY  in  1  sampled with START; 1 = add verify pass
- STATDATA  in  SIZESRSTAT  static word; captured at START
- DYNDATA  in  SIZESRDYN  dynamic word; captured at START
- SDO  in  1  chain serial output; synchronous to CLK, driven by the chain
- SCLK  out  1  chain shift clock; the chain samples SDI on its rising edge
- SEL  out  1  chain select; high while shifting, falling edge latches
- SDI  out  1  chain serial data
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  verify mismatch, sticky until next accepted START
- RDBK  out  N  SDO bits captured during the last pass; N = SIZESRSTAT+SIZESRDYN

## Operation
- Frame F[N-1:0] = {STATDATA, DYNDATA}, registered at START and shifted MSB first. After one pass, F[N-1] is at the SDO end of the chain.
- States:
  - IDLE: START goes to SHIFT with pass=0, bit=0, ERR cleared.
  - SHIFT: bit k drives SDI=F[N-1-k] for one full SCLK period.
  - LATCH: after bit N-1.
  - When LATCH ends: if pass=0 and VERIFY, go back to SHIFT with pass=1. Otherwise go to FINISH.
  - FINISH: DONE pulse, then IDLE.
- SCLK period = 2·HALF CLK cycles: low for HALF, then high for HALF. SDI and SEL change only while SCLK is low.
- SDO is sampled in the last CLK cycle of each low half, before the rising edge.
  - Bit k sample goes to RDBK[N-1-k].
  - In pass 1, if sample ≠ F[N-1-k], ERR=1.
- LATCH: SCLK=0, SDI=0. SEL stays high for HALF cycles, then low for HALF cycles.
- START while BUSY is ignored. VERIFY, STATDATA and DYNDATA are ignored except at an accepted START.
- Bit counter is $clog2(N) bits wide and counts 0..N-1 with no wrap. Half-period counter is $clog2(HALF) bits, min 1.
- Reset (including mid-transfer): all outputs 0 and state IDLE immediately. RDBK=0 and the frame register is cleared. No partial latch is issued. SEL falls asynchronously, so the chain must treat that edge as an abort.

## Timing
- START high in IDLE at edge t0. At t0+1: BUSY=1, SEL=1, SCLK=0, SDI=F[N-1].
- First SCLK rise at t0+1+HALF. Bit k rise at t0+1+HALF+2·HALF·k.
- SEL falls at t0+1+2·HALF·N+HALF.
- Single pass: DONE=1 and BUSY=0 at t0+1+2·HALF·(N+1), for one cycle. Defaults: t0+841.
- Verify: DONE at t0+1+4·HALF·(N+1). Defaults: t0+1681. ERR is valid in the same cycle as DONE.
- A new START is accepted in the cycle after DONE.

## Structure
- Package cfg_chain_pkg:
  - state enum: IDLE, SHIFT, LATCH, FINISH
  - default lengths and derived N
- Sub-module cfg_sclk_gen:
  - half-period counter
  - outputs SCLK plus `pre_rise` and `phase_end` strobes
  - enabled by the FSM
- Top contains the FSM, frame shift register, bit/pass counters and RDBK capture.

## Test plan
- Defaults, F=all-ones → 104 SCLK rises. SDI=1 at each rise. SEL falls at t0+837. DONE at t0+841. ERR=0.
- Chain model preloaded with 0xA5-pattern; load F=0 → RDBK equals the preload.
- VERIFY=1 with a correct chain model and random F → DONE at t0+1681, ERR=0, RDBK=F.
- VERIFY=1, chain model with bit 40 stuck at 0 and F[40]=1 → ERR=1 at DONE. ERR stays 1 until the next START clears it.
- START pulsed at t0+100 during a transfer → ignored. DONE timing is unchanged and the frame is unchanged.
- RST asserted at t0+300 → SEL/SCLK/SDI/BUSY go to 0 asynchronously, DONE is never pulsed, and the next START restarts cleanly.
